// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM states,
// interrupt codes, mstatus/mtvec field positions and the CSR addresses it writes.
package trap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        W_MTVAL,
        W_MSTATUS,
        REDIRECT
    } trap_state_e;

    localparam int unsigned IRQ_SW_CODE    = 3;
    localparam int unsigned IRQ_TIMER_CODE = 7;
    localparam int unsigned IRQ_EXT_CODE   = 11;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

endpackage

// File: rtl/trap_irq_sel.sv
// Picks the highest-priority enabled machine interrupt: external, then software, then timer.
module trap_irq_sel
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_mie,
    input  logic [XLEN-1:0] i_mip,
    input  logic            i_mstatus_mie,
    output logic            o_valid,
    output logic [4:0]      o_code
);

    logic [XLEN-1:0] w_enabled;

    assign w_enabled = i_mie & i_mip;

    // mip only ever carries bits 3/7/11, so any set bit here is one of the three sources.
    assign o_valid = i_mstatus_mie & (|w_enabled);

    always_comb begin
        o_code = 5'd0;
        if (w_enabled[IRQ_EXT_CODE]) begin
            o_code = 5'(IRQ_EXT_CODE);
        end else if (w_enabled[IRQ_SW_CODE]) begin
            o_code = 5'(IRQ_SW_CODE);
        end else if (w_enabled[IRQ_TIMER_CODE]) begin
            o_code = 5'(IRQ_TIMER_CODE);
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: serialises mepc/mcause/mtval/mstatus writes through
// the single CSR write port, then redirects fetch; otherwise passes WB CSR writes through.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              exc_valid_i,
    input  logic [3:0]        exc_cause_i,
    input  logic [XLEN-1:0]   exc_pc_i,
    input  logic [XLEN-1:0]   exc_tval_i,
    input  logic              mret_i,
    input  logic [XLEN-1:0]   int_pc_i,
    input  logic              irq_ext_i,
    input  logic              irq_timer_i,
    input  logic              irq_sw_i,
    input  logic [XLEN-1:0]   mstatus_i,
    input  logic [XLEN-1:0]   mie_i,
    input  logic [XLEN-1:0]   mtvec_i,
    input  logic [XLEN-1:0]   mepc_i,
    input  logic              wb_we_i,
    input  logic [CSR_AW-1:0] wb_waddr_i,
    input  logic [XLEN-1:0]   wb_wdata_i,
    output logic              csr_we_o,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic [XLEN-1:0]   mip_o,
    output logic              stall_o,
    output logic              flush_o,
    output logic              redirect_o,
    output logic [XLEN-1:0]   redirect_pc_o
);

    trap_state_e     r_state, w_next_state;
    logic            r_is_mret;
    logic [XLEN-1:0] r_epc, r_cause, r_tval, r_target;

    logic            w_idle, w_irq_valid, w_irq_blocked;
    logic            w_take_exc, w_take_irq, w_take_mret, w_accept;
    logic [4:0]      w_irq_code;
    logic [XLEN-1:0] w_base, w_target, w_cause, w_epc, w_tval, w_mstatus_new;

    always_comb begin
        mip_o                 = '0;
        mip_o[IRQ_EXT_CODE]   = irq_ext_i;
        mip_o[IRQ_TIMER_CODE] = irq_timer_i;
        mip_o[IRQ_SW_CODE]    = irq_sw_i;
    end

    trap_irq_sel #(.XLEN(XLEN)) u_irq_sel (
        .i_mie         (mie_i),
        .i_mip         (mip_o),
        .i_mstatus_mie (mstatus_i[MSTATUS_MIE]),
        .o_valid       (w_irq_valid),
        .o_code        (w_irq_code)
    );

    // A WB write to mstatus/mie may be disabling interrupts, so hold off acceptance a cycle.
    assign w_irq_blocked = wb_we_i & ((wb_waddr_i == CSR_AW'(CSR_MSTATUS)) |
                                      (wb_waddr_i == CSR_AW'(CSR_MIE)));

    assign w_idle      = (r_state == IDLE) & rst_ni;
    assign w_take_exc  = w_idle & exc_valid_i;
    assign w_take_irq  = w_idle & ~exc_valid_i & w_irq_valid & ~w_irq_blocked;
    assign w_take_mret = w_idle & ~exc_valid_i & ~(w_irq_valid & ~w_irq_blocked) & mret_i;
    assign w_accept    = w_take_exc | w_take_irq | w_take_mret;

    assign w_base = mtvec_i & ~XLEN'(3);

    always_comb begin
        w_epc    = exc_pc_i;
        w_tval   = exc_tval_i;
        w_cause  = {{(XLEN-4){1'b0}}, exc_cause_i};
        w_target = w_base;
        if (w_take_mret) begin
            w_target = mepc_i & ~XLEN'(3);
        end else if (w_take_irq) begin
            w_epc   = int_pc_i;
            w_tval  = '0;
            w_cause = {1'b1, {(XLEN-6){1'b0}}, w_irq_code};
            if (mtvec_i[1:0] == MTVEC_VECTORED) begin
                w_target = w_base + (XLEN'(w_irq_code) << 2);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_is_mret <= 1'b0;
            r_epc     <= '0;
            r_cause   <= '0;
            r_tval    <= '0;
            r_target  <= '0;
        end else if (w_accept) begin
            r_is_mret <= w_take_mret;
            r_epc     <= w_epc;
            r_cause   <= w_cause;
            r_tval    <= w_tval;
            r_target  <= w_target;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_take_exc | w_take_irq) begin
                    w_next_state = W_MEPC;
                end else if (w_take_mret) begin
                    w_next_state = W_MSTATUS;
                end
            end
            W_MEPC:    w_next_state = W_MCAUSE;
            W_MCAUSE:  w_next_state = W_MTVAL;
            W_MTVAL:   w_next_state = W_MSTATUS;
            W_MSTATUS: w_next_state = REDIRECT;
            REDIRECT:  w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_mstatus_new = mstatus_i;
        if (r_is_mret) begin
            w_mstatus_new[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
            w_mstatus_new[MSTATUS_MPIE] = 1'b1;
        end else begin
            w_mstatus_new[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
            w_mstatus_new[MSTATUS_MIE]  = 1'b0;
        end
        w_mstatus_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    always_comb begin
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        case (r_state)
            IDLE: begin
                // The faulting instruction must not retire, so its CSR write is dropped.
                csr_we_o    = wb_we_i & rst_ni & ~w_take_exc;
                csr_waddr_o = wb_waddr_i;
                csr_wdata_o = wb_wdata_i;
            end
            W_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_AW'(CSR_MEPC);
                csr_wdata_o = r_epc;
            end
            W_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_AW'(CSR_MCAUSE);
                csr_wdata_o = r_cause;
            end
            W_MTVAL: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_AW'(CSR_MTVAL);
                csr_wdata_o = r_tval;
            end
            W_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_AW'(CSR_MSTATUS);
                csr_wdata_o = w_mstatus_new;
            end
            default: begin
                csr_we_o = 1'b0;
            end
        endcase
    end

    assign stall_o       = (r_state != IDLE) | w_accept;
    assign flush_o       = (r_state == REDIRECT);
    assign redirect_o    = (r_state == REDIRECT);
    assign redirect_pc_o = r_target;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized requests
// compared against a rule-level model of the expected CSR write sequence.
module tb_trap_ctrl;

    typedef struct {
        logic        exc;
        logic [3:0]  ecause;
        logic [31:0] pc;
        logic [31:0] tval;
        logic        mret;
        logic [31:0] intPc;
        logic        ext;
        logic        timer;
        logic        sw;
        logic [31:0] mstatus;
        logic [31:0] mie;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        wbWe;
        logic [11:0] wbAddr;
        logic [31:0] wbData;
    } req_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk_i, rst_ni;
    logic        exc_valid_i, mret_i, irq_ext_i, irq_timer_i, irq_sw_i, wb_we_i;
    logic [3:0]  exc_cause_i;
    logic [31:0] exc_pc_i, exc_tval_i, int_pc_i, mstatus_i, mie_i, mtvec_i, mepc_i, wb_wdata_i;
    logic [11:0] wb_waddr_i, csr_waddr_o;
    logic        csr_we_o, stall_o, flush_o, redirect_o;
    logic [31:0] csr_wdata_o, mip_o, redirect_pc_o;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] shadowMepc = 32'h0;

    trap_ctrl #(.XLEN(32), .CSR_AW(12)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .exc_valid_i  (exc_valid_i),
        .exc_cause_i  (exc_cause_i),
        .exc_pc_i     (exc_pc_i),
        .exc_tval_i   (exc_tval_i),
        .mret_i       (mret_i),
        .int_pc_i     (int_pc_i),
        .irq_ext_i    (irq_ext_i),
        .irq_timer_i  (irq_timer_i),
        .irq_sw_i     (irq_sw_i),
        .mstatus_i    (mstatus_i),
        .mie_i        (mie_i),
        .mtvec_i      (mtvec_i),
        .mepc_i       (mepc_i),
        .wb_we_i      (wb_we_i),
        .wb_waddr_i   (wb_waddr_i),
        .wb_wdata_i   (wb_wdata_i),
        .csr_we_o     (csr_we_o),
        .csr_waddr_o  (csr_waddr_o),
        .csr_wdata_o  (csr_wdata_o),
        .mip_o        (mip_o),
        .stall_o      (stall_o),
        .flush_o      (flush_o),
        .redirect_o   (redirect_o),
        .redirect_pc_o(redirect_pc_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Stand-in for csr_file's mepc so writes that survive a reset can be observed.
    always @(posedge clk_i) begin
        if (csr_we_o && csr_waddr_o == 12'h341) shadowMepc <= csr_wdata_o;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic req_t idleReq();
        req_t r;
        r.exc = 0; r.ecause = 0; r.pc = 0; r.tval = 0; r.mret = 0; r.intPc = 0;
        r.ext = 0; r.timer = 0; r.sw = 0; r.mstatus = 0; r.mie = 0; r.mtvec = 0;
        r.mepc = 0; r.wbWe = 0; r.wbAddr = 0; r.wbData = 0;
        return r;
    endfunction

    task automatic applyStimulus(input req_t r);
        exc_valid_i = r.exc;   exc_cause_i = r.ecause; exc_pc_i = r.pc; exc_tval_i = r.tval;
        mret_i      = r.mret;  int_pc_i    = r.intPc;
        irq_ext_i   = r.ext;   irq_timer_i = r.timer;  irq_sw_i = r.sw;
        mstatus_i   = r.mstatus; mie_i = r.mie; mtvec_i = r.mtvec; mepc_i = r.mepc;
        wb_we_i     = r.wbWe;  wb_waddr_i  = r.wbAddr; wb_wdata_i = r.wbData;
    endtask

    task automatic clearRequests();
        exc_valid_i = 0; mret_i = 0; irq_ext_i = 0; irq_timer_i = 0; irq_sw_i = 0;
    endtask

    function automatic logic [31:0] expMip(input req_t r);
        return (32'(r.ext) << 11) | (32'(r.timer) << 7) | (32'(r.sw) << 3);
    endfunction

    // kind: 0 nothing accepted, 1 exception, 2 interrupt, 3 mret
    function automatic void modelTrap(input req_t r, output int kind, output logic [31:0] epc,
                                      output logic [31:0] cause, output logic [31:0] tval,
                                      output logic [31:0] target, output logic [31:0] msNew);
        int          prio[3] = '{11, 3, 7};
        bit          blocked = r.wbWe && (r.wbAddr == 12'h300 || r.wbAddr == 12'h304);
        logic [31:0] pend = expMip(r) & r.mie;
        int          code = -1;
        if (r.mstatus[3] && !blocked) begin
            for (int i = 0; i < 3; i++) begin
                if (code < 0 && pend[prio[i]]) code = prio[i];
            end
        end
        kind = 0; epc = 0; cause = 0; tval = 0; target = 0; msNew = 0;
        if (r.exc) kind = 1;
        else if (code >= 0) kind = 2;
        else if (r.mret) kind = 3;
        if (kind == 1) begin
            epc = r.pc; cause = {28'b0, r.ecause}; tval = r.tval; target = r.mtvec & ~32'h3;
        end else if (kind == 2) begin
            epc = r.intPc; cause = 32'h8000_0000 | 32'(code); tval = 0;
            target = (r.mtvec & ~32'h3) + ((r.mtvec[1:0] == 2'b01) ? 32'(4 * code) : 32'h0);
        end else if (kind == 3) begin
            target = r.mepc & ~32'h3;
        end
        if (kind == 3)
            msNew = (r.mstatus & ~32'h1888) | (((r.mstatus >> 7) & 1) << 3) | 32'h80 | 32'h1800;
        else
            msNew = (r.mstatus & ~32'h1888) | (((r.mstatus >> 3) & 1) << 7) | 32'h1800;
    endfunction

    task automatic runCase(input string tag, input req_t r);
        int          kind;
        logic [31:0] epc, cause, tval, target, msNew;
        wr_t         q[$];
        applyStimulus(r);
        #1;
        modelTrap(r, kind, epc, cause, tval, target, msNew);
        checkOutput({tag, ":mip"}, mip_o, expMip(r));
        checkOutput({tag, ":accept_stall"}, 32'(stall_o), 32'(kind != 0));
        checkOutput({tag, ":accept_we"}, 32'(csr_we_o), (kind == 1) ? 32'h0 : 32'(r.wbWe));
        if (kind != 1 && r.wbWe) begin
            checkOutput({tag, ":pass_addr"}, 32'(csr_waddr_o), 32'(r.wbAddr));
            checkOutput({tag, ":pass_data"}, csr_wdata_o, r.wbData);
        end
        if (kind == 0) begin
            step();
            return;
        end
        if (kind != 3) begin
            q.push_back('{12'h341, epc});
            q.push_back('{12'h342, cause});
            q.push_back('{12'h343, tval});
        end
        q.push_back('{12'h300, msNew});
        step();
        clearRequests();
        foreach (q[i]) begin
            wb_we_i = 1; wb_waddr_i = 12'($urandom); wb_wdata_i = $urandom;
            #1;
            checkOutput({tag, ":seq_we"}, 32'(csr_we_o), 32'h1);
            checkOutput({tag, ":seq_addr"}, 32'(csr_waddr_o), 32'(q[i].addr));
            checkOutput({tag, ":seq_data"}, csr_wdata_o, q[i].data);
            checkOutput({tag, ":seq_stall"}, 32'(stall_o), 32'h1);
            checkOutput({tag, ":seq_redirect"}, 32'(redirect_o), 32'h0);
            step();
        end
        wb_we_i = 0;
        #1;
        checkOutput({tag, ":redirect"}, 32'(redirect_o), 32'h1);
        checkOutput({tag, ":flush"}, 32'(flush_o), 32'h1);
        checkOutput({tag, ":redirect_pc"}, redirect_pc_o, target);
        checkOutput({tag, ":redirect_we"}, 32'(csr_we_o), 32'h0);
        step();
        checkOutput({tag, ":after_redirect"}, 32'(redirect_o), 32'h0);
        checkOutput({tag, ":after_stall"}, 32'(stall_o), 32'h0);
        checkOutput({tag, ":after_we"}, 32'(csr_we_o), 32'h0);
    endtask

    initial begin
        req_t r;
        rst_ni = 0;
        applyStimulus(idleReq());
        #3;
        checkOutput("reset_we", 32'(csr_we_o), 32'h0);
        checkOutput("reset_stall", 32'(stall_o), 32'h0);
        checkOutput("reset_flush", 32'(flush_o), 32'h0);
        checkOutput("reset_redirect", 32'(redirect_o), 32'h0);
        checkOutput("reset_pc", redirect_pc_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1;
        step();

        r = idleReq();
        r.exc = 1; r.ecause = 4'd2; r.pc = 32'h100; r.tval = 32'hDEADBEEF;
        r.mtvec = 32'h200; r.mstatus = 32'h8;
        r.wbWe = 1; r.wbAddr = 12'h340; r.wbData = 32'h5555_AAAA;
        runCase("exc_basic", r);

        r = idleReq();
        r.timer = 1; r.mie = 32'h80; r.mstatus = 32'h8; r.mtvec = 32'h301; r.intPc = 32'h888;
        r.wbWe = 1; r.wbAddr = 12'h340; r.wbData = 32'h1234_5678;
        runCase("irq_timer_vec", r);

        r = idleReq();
        r.ext = 1; r.timer = 1; r.mie = 32'h880; r.mstatus = 32'h8; r.mtvec = 32'h400;
        runCase("irq_ext_over_timer", r);

        r.mstatus = 32'h0;
        runCase("irq_mie_off", r);

        r = idleReq();
        r.mret = 1; r.mstatus = 32'h1880; r.mepc = 32'h404;
        runCase("mret", r);

        r = idleReq();
        r.exc = 1; r.ecause = 4'd11; r.pc = 32'h700; r.mret = 1; r.mepc = 32'h900; r.mtvec = 32'h180;
        runCase("exc_over_mret", r);

        r = idleReq();
        r.sw = 1; r.mie = 32'h8; r.mstatus = 32'h8; r.mtvec = 32'h501; r.intPc = 32'h44;
        r.wbWe = 1; r.wbAddr = 12'h300; r.wbData = 32'h8;
        runCase("irq_deferred", r);
        r.wbWe = 0;
        runCase("irq_after_defer", r);

        // Reset asserted while the mcause write is on the port.
        r = idleReq();
        r.exc = 1; r.ecause = 4'd5; r.pc = 32'h1234_5678; r.mtvec = 32'h200;
        applyStimulus(r);
        step();
        clearRequests();
        step();
        rst_ni = 0;
        #1;
        checkOutput("midrst_we", 32'(csr_we_o), 32'h0);
        checkOutput("midrst_stall", 32'(stall_o), 32'h0);
        checkOutput("midrst_flush", 32'(flush_o), 32'h0);
        checkOutput("midrst_redirect", 32'(redirect_o), 32'h0);
        checkOutput("midrst_pc", redirect_pc_o, 32'h0);
        checkOutput("midrst_mepc_kept", shadowMepc, 32'h1234_5678);
        @(negedge clk_i);
        rst_ni = 1;
        step();
        r.pc = 32'h2468;
        runCase("exc_after_reset", r);

        for (int n = 0; n < 40; n++) begin
            r = idleReq();
            r.exc     = ($urandom_range(0, 3) == 0);
            r.ecause  = 4'($urandom);
            r.pc      = $urandom;
            r.tval    = $urandom;
            r.mret    = ($urandom_range(0, 2) == 0);
            r.intPc   = $urandom;
            r.ext     = 1'($urandom_range(0, 1));
            r.timer   = 1'($urandom_range(0, 1));
            r.sw      = 1'($urandom_range(0, 1));
            r.mstatus = $urandom;
            r.mie     = $urandom;
            r.mtvec   = ($urandom & ~32'h3) | 32'($urandom_range(0, 1));
            r.mepc    = $urandom;
            r.wbWe    = 1'($urandom_range(0, 1));
            r.wbAddr  = ($urandom_range(0, 2) == 0) ? 12'h304 : 12'($urandom);
            r.wbData  = $urandom;
            runCase($sformatf("rand%0d", n), r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
